// File: rtl/obi_pkg.sv
// obi_pkg: shared types and arbitration-mode constants for the OBI arbiter
package obi_pkg;
    typedef logic master_id_t;
    localparam master_id_t M_INSTR = 1'b0;
    localparam master_id_t M_DATA = 1'b1;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR = 1;
endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: synchronous FIFO holding the master IDs of in-flight transactions
module obi_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (i_pop) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_head = r_mem[r_rptr];
    assign o_full = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/obi_bus_arbiter.sv
// obi_bus_arbiter: shares one OBI slave port between the instruction and data masters,
// routing in-order responses back to the issuing master
module obi_bus_arbiter import obi_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RR_MODE = ARB_RR,
    localparam int BE_W = DATA_W / 8,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_m0_req,
    output logic              o_m0_gnt,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_we,
    input  logic [BE_W-1:0]   i_m0_be,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,
    input  logic              i_m1_req,
    output logic              o_m1_gnt,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_we,
    input  logic [BE_W-1:0]   i_m1_be,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,
    output logic              o_s_req,
    input  logic              i_s_gnt,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic              o_s_we,
    output logic [BE_W-1:0]   o_s_be,
    output logic [DATA_W-1:0] o_s_wdata,
    input  logic              i_s_rvalid,
    input  logic [DATA_W-1:0] i_s_rdata,
    input  logic              i_s_err,
    output logic              o_proto_err
);
    master_id_t w_sel, w_head, r_lock_id, r_rr;
    logic r_locked, r_proto_err, w_sel_req, w_hs, w_rsp, w_full, w_empty;
    logic [CW-1:0] w_count;
    // A stalled request keeps its master until the slave accepts it
    assign w_sel = r_locked ? r_lock_id :
                   (i_m0_req && i_m1_req) ? ((RR_MODE == ARB_RR) ? r_rr : M_DATA) :
                   (i_m1_req ? M_DATA : M_INSTR);
    assign w_sel_req = (w_sel == M_DATA) ? i_m1_req : i_m0_req;
    assign o_s_req = w_sel_req & ~w_full;
    assign o_s_addr = (w_sel == M_DATA) ? i_m1_addr : i_m0_addr;
    assign o_s_we = (w_sel == M_DATA) ? i_m1_we : i_m0_we;
    assign o_s_be = (w_sel == M_DATA) ? i_m1_be : i_m0_be;
    assign o_s_wdata = (w_sel == M_DATA) ? i_m1_wdata : i_m0_wdata;
    assign w_hs = o_s_req & i_s_gnt;
    assign o_m0_gnt = w_hs & (w_sel == M_INSTR);
    assign o_m1_gnt = w_hs & (w_sel == M_DATA);
    assign w_rsp = i_s_rvalid & ~w_empty;
    assign o_m0_rvalid = w_rsp & (w_head == M_INSTR);
    assign o_m1_rvalid = w_rsp & (w_head == M_DATA);
    assign o_m0_err = o_m0_rvalid & i_s_err;
    assign o_m1_err = o_m1_rvalid & i_s_err;
    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;
    assign o_proto_err = r_proto_err;
    obi_id_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_ids (
        .clk(clk),
        .rst(rst),
        .i_push(w_hs),
        .i_pop(w_rsp),
        .i_din(w_sel),
        .o_head(w_head),
        .o_full(w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
            r_lock_id <= M_INSTR;
            r_rr <= M_INSTR;
            r_proto_err <= 1'b0;
        end else begin
            r_locked <= o_s_req & ~i_s_gnt;
            r_lock_id <= w_sel;
            if (w_hs) r_rr <= (w_sel == M_DATA) ? M_INSTR : M_DATA;
            if (i_s_rvalid && w_count == '0) r_proto_err <= 1'b1;
        end
    end
endmodule
